// File: rtl/led_seq_ctrl_if.sv
// Configuration write channel for led_seq_ctrl: valid/ready handshake carrying one table entry.
interface led_seq_ctrl_if #(
  parameter int unsigned NSTEP = 4
);
  localparam int unsigned IW = $clog2(NSTEP);

  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [IW-1:0] cfg_idx_i;
  logic [4:0]    cfg_div_i;
  logic [7:0]    cfg_hold_i;

  modport master (
    output cfg_valid_i, cfg_idx_i, cfg_div_i, cfg_hold_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i, cfg_idx_i, cfg_div_i, cfg_hold_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// Steps an LED blink counter through a table of {divisor, dwell} entries, advancing
// after a programmed number of LED toggles and restarting the counter on each step.
module led_seq_ctrl #(
  parameter int unsigned NSTEP = 4
) (
  input  logic                     clk100,
  input  logic                     rstn,
  input  logic                     en_i,
  input  logic                     led_i,
  led_seq_ctrl_if.slave            cfg,
  output logic [4:0]               div_o,
  output logic                     wren_o,
  output logic [$clog2(NSTEP)-1:0] step_o,
  output logic                     wrap_o
);
  localparam int unsigned IW = $clog2(NSTEP);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ADVANCE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    tbl_div_q  [NSTEP];
  logic [4:0]    tbl_div_d  [NSTEP];
  logic [7:0]    tbl_hold_q [NSTEP];
  logic [7:0]    tbl_hold_d [NSTEP];
  logic [7:0]    hold_cur_q, hold_cur_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [1:0]    mask_q, mask_d;
  logic          led_q, led_d;
  logic [4:0]    div_q, div_d;
  logic          wren_q, wren_d;
  logic          wrap_q, wrap_d;
  logic [IW-1:0] step_q, step_d;
  logic          ready_q, ready_d;

  logic          wr_en;
  logic          tog_cnt;
  logic          match;
  logic          last_step;
  logic [IW-1:0] step_nxt;

  // Next-state, table update and output computation
  always_comb begin
    tbl_div_d  = tbl_div_q;
    tbl_hold_d = tbl_hold_q;
    state_d    = state_q;
    hold_cur_d = hold_cur_q;
    div_d      = div_q;
    step_d     = step_q;
    wren_d     = 1'b0;
    wrap_d     = 1'b0;
    led_d      = led_i;

    wr_en = cfg.cfg_valid_i && ready_q && (32'(cfg.cfg_idx_i) < NSTEP);
    if (wr_en) begin
      tbl_div_d[cfg.cfg_idx_i]  = cfg.cfg_div_i;
      tbl_hold_d[cfg.cfg_idx_i] = cfg.cfg_hold_i;
    end

    // The counter's own restart toggle lands inside the mask window
    tog_cnt   = (state_q == RUN) && (mask_q == 2'd0) && (led_i ^ led_q);
    match     = tog_cnt && ((tcnt_q + 8'd1) == hold_cur_q);
    tcnt_d    = tog_cnt ? tcnt_q + 8'd1 : tcnt_q;
    mask_d    = (mask_q != 2'd0) ? mask_q - 2'd1 : 2'd0;
    last_step = (step_q == IW'(NSTEP - 1));
    step_nxt  = last_step ? '0 : step_q + IW'(1);

    if (!en_i) begin
      state_d = IDLE;
      step_d  = '0;
      div_d   = tbl_div_q[0];
      tcnt_d  = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          state_d    = RUN;
          step_d     = '0;
          div_d      = tbl_div_q[0];
          hold_cur_d = tbl_hold_q[0];
          wren_d     = 1'b1;
          tcnt_d     = 8'd0;
          mask_d     = 2'd3;
        end
        RUN: if (match) state_d = ADVANCE;
        ADVANCE: begin
          state_d    = RUN;
          step_d     = step_nxt;
          div_d      = tbl_div_q[step_nxt];
          hold_cur_d = tbl_hold_q[step_nxt];
          wren_d     = 1'b1;
          wrap_d     = last_step;
          tcnt_d     = 8'd0;
          mask_d     = 2'd3;
        end
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      hold_cur_q <= 8'd4;
      tcnt_q     <= 8'd0;
      mask_q     <= 2'd0;
      led_q      <= 1'b0;
      div_q      <= 5'h01;
      wren_q     <= 1'b0;
      wrap_q     <= 1'b0;
      step_q     <= '0;
      ready_q    <= 1'b1;
      for (int i = 0; i < NSTEP; i++) begin
        tbl_div_q[i]  <= 5'(32'd1 << (i % 5));
        tbl_hold_q[i] <= 8'd4;
      end
    end else begin
      state_q    <= state_d;
      hold_cur_q <= hold_cur_d;
      tcnt_q     <= tcnt_d;
      mask_q     <= mask_d;
      led_q      <= led_d;
      div_q      <= div_d;
      wren_q     <= wren_d;
      wrap_q     <= wrap_d;
      step_q     <= step_d;
      ready_q    <= ready_d;
      tbl_div_q  <= tbl_div_d;
      tbl_hold_q <= tbl_hold_d;
    end
  end

  assign cfg.cfg_ready_o = ready_q;
  assign div_o           = div_q;
  assign wren_o          = wren_q;
  assign wrap_o          = wrap_q;
  assign step_o          = step_q;
endmodule
